// File: rtl/csel_pkg.sv
// Shared definitions for the carry-select subtractor pipeline.
package csel_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int STAGE_SIZE_DEF = 4;

    typedef logic [STAGE_SIZE_DEF-1:0] chunk_t;

    // Signed overflow of a - b: operands of opposite sign and a result whose
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/csel_sub_slice.sv
// One pipeline slice: resolves CHUNKS carry-select chunks of a + ~b + cin
// starting at bit SLICE_IDX*CHUNKS*STAGE_SIZE, then registers the partial
// difference, the outgoing carry and the operands for the following slices.
module csel_sub_slice
    import csel_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STAGE_SIZE = STAGE_SIZE_DEF,
    parameter int CHUNKS     = 4,
    parameter int SLICE_IDX  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  v_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] nb_in,
    input  logic [DATA_WIDTH-1:0] diff_in,
    input  logic                  carry_in,
    output logic                  v_out,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] nb_out,
    output logic [DATA_WIDTH-1:0] diff_out,
    output logic                  carry_out
);

    localparam int SLICE_W = STAGE_SIZE * CHUNKS;
    localparam int LO      = SLICE_IDX * SLICE_W;

    logic [SLICE_W-1:0]    slice_sum_s;
    logic [DATA_WIDTH-1:0] diff_next_s;
    logic                  carry_next_s;
    logic                  v_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] nb_r;
    logic [DATA_WIDTH-1:0] diff_r;
    logic                  carry_r;

    for (genvar j = 0; j < CHUNKS; j++) begin : chunk_g
        localparam int BASE = LO + j * STAGE_SIZE;
        logic [STAGE_SIZE-1:0] s0_s;
        logic [STAGE_SIZE-1:0] s1_s;
        logic                  sel_s;
        logic                  cnext_s;

        // Two ripple chains per chunk: one assuming carry-in 0, one assuming 1.
        for (genvar i = 0; i < STAGE_SIZE; i++) begin : bit_g
            logic ci0_s;
            logic ci1_s;
            logic c0_s;
            logic c1_s;
            if (i == 0) begin : g_first
                assign ci0_s = 1'b0;
                assign ci1_s = 1'b1;
            end else begin : g_rest
                assign ci0_s = bit_g[i-1].c0_s;
                assign ci1_s = bit_g[i-1].c1_s;
            end
            fulladder u_fa0 (.a(a_in[BASE+i]), .b(nb_in[BASE+i]), .ci(ci0_s), .s(s0_s[i]), .co(c0_s));
            fulladder u_fa1 (.a(a_in[BASE+i]), .b(nb_in[BASE+i]), .ci(ci1_s), .s(s1_s[i]), .co(c1_s));
        end

        if (j == 0) begin : g_sel_first
            assign sel_s = carry_in;
        end else begin : g_sel_rest
            assign sel_s = chunk_g[j-1].cnext_s;
        end

        mux2 #(.W(STAGE_SIZE)) u_sum_mux (
            .d0 (s0_s),
            .d1 (s1_s),
            .sel(sel_s),
            .y  (slice_sum_s[j*STAGE_SIZE +: STAGE_SIZE])
        );
        mux2 #(.W(1)) u_carry_mux (
            .d0 (bit_g[STAGE_SIZE-1].c0_s),
            .d1 (bit_g[STAGE_SIZE-1].c1_s),
            .sel(sel_s),
            .y  (cnext_s)
        );
    end

    assign carry_next_s = chunk_g[CHUNKS-1].cnext_s;

    // Merge this slice's bits into the partial difference; bits not yet
    // resolved are always zero, so an OR places them without masking.
    always_comb begin
        diff_next_s = diff_in | ({{(DATA_WIDTH-SLICE_W){1'b0}}, slice_sum_s} << LO);
    end

    // Slice register: valid follows the handshake, data loads only with a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r     <= 1'b0;
            a_r     <= '0;
            nb_r    <= '0;
            diff_r  <= '0;
            carry_r <= 1'b1;
        end else if (load) begin
            v_r <= v_in;
            if (v_in) begin
                a_r     <= a_in;
                nb_r    <= nb_in;
                diff_r  <= diff_next_s;
                carry_r <= carry_next_s;
            end
        end
    end

    assign v_out     = v_r;
    assign a_out     = a_r;
    assign nb_out    = nb_r;
    assign diff_out  = diff_r;
    assign carry_out = carry_r;

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mux2.sv
// Two-input multiplexer cell of configurable width.
module mux2 #(
    parameter int W = 1
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/csel_sub_pipe.sv
// Pipelined carry-select subtractor: diff = a - b - bi, computed as
// a + ~b + ~bi over PIPE_STAGES register slices with valid/ready flow control.
module csel_sub_pipe
    import csel_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int STAGE_SIZE  = STAGE_SIZE_DEF,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  bo,
    output logic                  ovf
);

    localparam int STAGE_NUM = DATA_WIDTH / STAGE_SIZE;
    localparam int CPP       = STAGE_NUM / PIPE_STAGES;

    // Index 0 carries the incoming operands; index k+1 is the output of slice k.
    logic                  v_s     [PIPE_STAGES+1];
    logic [DATA_WIDTH-1:0] a_s     [PIPE_STAGES+1];
    logic [DATA_WIDTH-1:0] nb_s    [PIPE_STAGES+1];
    logic [DATA_WIDTH-1:0] diff_s  [PIPE_STAGES+1];
    logic                  carry_s [PIPE_STAGES+1];
    logic [PIPE_STAGES:0]  ready_s;

    assign v_s[0]     = in_valid;
    assign a_s[0]     = a;
    assign nb_s[0]    = ~b;
    assign diff_s[0]  = '0;
    assign carry_s[0] = ~bi;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : slice_g
        csel_sub_slice #(
            .DATA_WIDTH(DATA_WIDTH),
            .STAGE_SIZE(STAGE_SIZE),
            .CHUNKS    (CPP),
            .SLICE_IDX (k)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ready_s[k]),
            .v_in     (v_s[k]),
            .a_in     (a_s[k]),
            .nb_in    (nb_s[k]),
            .diff_in  (diff_s[k]),
            .carry_in (carry_s[k]),
            .v_out    (v_s[k+1]),
            .a_out    (a_s[k+1]),
            .nb_out   (nb_s[k+1]),
            .diff_out (diff_s[k+1]),
            .carry_out(carry_s[k+1])
        );
    end

    // Ready chain: a slice may load when the slice after it is empty or moving on.
    always_comb begin
        ready_s              = '0;
        ready_s[PIPE_STAGES] = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            ready_s[k] = !v_s[k+1] || ready_s[k+1];
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = v_s[PIPE_STAGES];
    assign diff      = diff_s[PIPE_STAGES];
    assign bo        = ~carry_s[PIPE_STAGES];
    assign ovf       = sub_ovf(a_s[PIPE_STAGES][DATA_WIDTH-1],
                               ~nb_s[PIPE_STAGES][DATA_WIDTH-1],
                               diff_s[PIPE_STAGES][DATA_WIDTH-1]);

endmodule

// File: tb/tb_csel_sub_pipe.sv
// Bench for csel_sub_pipe: directed table, random streams with and without
// backpressure, and a mid-burst reset; results checked through a scoreboard.
module tb_csel_sub_pipe;

    localparam int DW = 32;
    localparam int PS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = 32'h0;
    logic [DW-1:0] b = 32'h0;
    logic          bi = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] diff;
    logic          bo;
    logic          ovf;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bi;
        logic [DW-1:0] d;
        logic          bo;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          bo;
        logic          ovf;
    } res_t;

    res_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    bit   rand_ready = 1'b0;
    bit   stall_prev = 1'b0;
    res_t held;
    res_t mon_e;
    logic exp_ir;

    csel_sub_pipe #(.DATA_WIDTH(DW), .STAGE_SIZE(4), .PIPE_STAGES(PS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bi       (bi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bo       (bo),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic res_t model(input logic [DW-1:0] va, input logic [DW-1:0] vb, input logic vbi);
        res_t r;
        logic [DW:0] t;
        t     = {1'b0, va} - {1'b0, vb} - {{DW{1'b0}}, vbi};
        r.d   = t[DW-1:0];
        r.bo  = t[DW];
        r.ovf = (va[DW-1] != vb[DW-1]) && (t[DW-1] != va[DW-1]);
        return r;
    endfunction

    task automatic tick_ready();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] va, input logic [DW-1:0] vb, input logic vbi,
                        input res_t exp, inout int waits);
        bit acc;
        int tries;
        tries = 0;
        @(negedge clk);
        tick_ready();
        in_valid = 1'b1;
        a = va;
        b = vb;
        bi = vbi;
        forever begin
            #4;
            acc = in_ready;
            if (acc) sb_q.push_back(exp);
            @(posedge clk);
            if (acc) break;
            waits++;
            tries++;
            if (tries > 500) begin
                chk("send_timeout", 64'(tries), 64'd0);
                break;
            end
            @(negedge clk);
            tick_ready();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = {DW{1'bx}};
            b = {DW{1'bx}};
            tick_ready();
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Output monitor: ready rule, stall stability, and in-order scoreboard compare.
    always begin
        @(negedge clk);
        #3;
        if (mon_en) begin
            exp_ir = (sb_q.size() < PS) || out_ready;
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_diff", 64'(diff), 64'(held.d));
                chk("hold_bo", 64'(bo), 64'(held.bo));
                chk("hold_ovf", 64'(ovf), 64'(held.ovf));
            end
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'd0);
                end else if (out_ready) begin
                    mon_e = sb_q.pop_front();
                    chk("diff", 64'(diff), 64'(mon_e.d));
                    chk("bo", 64'(bo), 64'(mon_e.bo));
                    chk("ovf", 64'(ovf), 64'(mon_e.ovf));
                end
            end
            stall_prev = out_valid && !out_ready;
            held.d     = diff;
            held.bo    = bo;
            held.ovf   = ovf;
        end else begin
            stall_prev = 1'b0;
        end
    end

    vec_t tbl[8];

    initial begin
        int   waits;
        res_t e;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rbi;

        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bo", 64'(bo), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Latency of exactly PS cycles on an empty pipe
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0005;
        b = 32'h0000_0003;
        bi = 1'b0;
        #4;
        chk("lat_in_ready", 64'(in_ready), 64'd1);
        sb_q.push_back(model(32'h0000_0005, 32'h0000_0003, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        chk("lat_diff", 64'(diff), 64'h2);
        drain();

        // Directed table
        waits = 0;
        for (int i = 0; i < 8; i++) begin
            e.d = tbl[i].d;
            e.bo = tbl[i].bo;
            e.ovf = tbl[i].ovf;
            send(tbl[i].a, tbl[i].b, tbl[i].bi, e, waits);
        end
        drain();

        // Back-to-back random stream, no backpressure
        waits = 0;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            rbi = 1'($urandom_range(0, 1));
            send(ra, rb, rbi, model(ra, rb, rbi), waits);
        end
        chk("b2b_no_stall", 64'(waits), 64'd0);
        drain();

        // Random backpressure with continuous input
        rand_ready = 1'b1;
        waits = 0;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rbi = 1'($urandom_range(0, 1));
            send(ra, rb, rbi, model(ra, rb, rbi), waits);
        end
        drain();
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Reset mid-burst: fill pipe, hold a third beat, then reset
        out_ready = 1'b0;
        waits = 0;
        send(32'h0000_0010, 32'h0000_0001, 1'b0, model(32'h0000_0010, 32'h0000_0001, 1'b0), waits);
        send(32'h0000_0020, 32'h0000_0002, 1'b0, model(32'h0000_0020, 32'h0000_0002, 1'b0), waits);
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0030;
        b = 32'h0000_0003;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_full_ready", 64'(in_ready), 64'd0);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        waits = 0;
        send(32'h0000_0009, 32'h0000_0004, 1'b1, model(32'h0000_0009, 32'h0000_0004, 1'b1), waits);
        drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
